// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipe_pkg
// Brief  : Shared definitions for the pipeline stage register.
//          - Stage occupancy encoding (EMPTY / ONE / FULL)
//          - Default PC value shown after reset or flush
//          - Bit offsets of the fields packed into the control payload:
//              [1:0] MemtoReg, [2] RegWr, [7:3] WrAddr
//          - pack_ctrl(): assembles a control word from its fields
// Rev    : 1.0  initial release
// ============================================================================
package pipe_pkg;

  // Occupancy of the stage: nothing held, main only, main plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  // PC presented on pc_out while no entry has been loaded since reset/flush.
  localparam logic [31:0] C_PC_RESET_DEFAULT = 32'h8000_0000;

  // Control payload field layout.
  localparam int C_CTRL_MEMTOREG_LSB = 0;
  localparam int C_CTRL_MEMTOREG_W   = 2;
  localparam int C_CTRL_REGWR_BIT    = 2;
  localparam int C_CTRL_WRADDR_LSB   = 3;
  localparam int C_CTRL_WRADDR_W     = 5;
  localparam int C_CTRL_MIN_W        = C_CTRL_WRADDR_LSB + C_CTRL_WRADDR_W;

  // Build an 8-bit control word from its fields using the offsets above.
  function automatic logic [C_CTRL_MIN_W-1:0] pack_ctrl(
    input logic [C_CTRL_MEMTOREG_W-1:0] mem_to_reg,
    input logic                         reg_wr,
    input logic [C_CTRL_WRADDR_W-1:0]   wr_addr
  );
    logic [C_CTRL_MIN_W-1:0] w_ctrl;
    w_ctrl = '0;
    w_ctrl[C_CTRL_MEMTOREG_LSB +: C_CTRL_MEMTOREG_W] = mem_to_reg;
    w_ctrl[C_CTRL_REGWR_BIT]                         = reg_wr;
    w_ctrl[C_CTRL_WRADDR_LSB +: C_CTRL_WRADDR_W]     = wr_addr;
    return w_ctrl;
  endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/stall_counter.sv
`default_nettype none
// ============================================================================
// Module : stall_counter
// Brief  : 32-bit free-running event counter used to count back-pressure
//          cycles of the pipeline stage. Wraps from 32'hFFFF_FFFF to 0.
//          Only instantiated when PIPE_STAGE_STALL_CNT_EN is defined.
// Ports  : clk    in   clock, state changes on posedge
//          reset  in   synchronous active-low reset (clears the count)
//          inc_i  in   count this cycle
//          cnt_o  out  current count
// Rev    : 1.0  initial release
// ============================================================================
module stall_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // Natural 32-bit overflow provides the wrap to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : stall_counter
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module : pipe_stage_reg
// Brief  : Valid/ready pipeline register with a one-entry skid buffer.
//          Latency 1, full throughput while downstream is ready. in_ready is
//          registered, so there is no combinational out_ready -> in_ready
//          path; the skid register absorbs the one entry that may arrive in
//          the cycle downstream stalls.
// Config : PIPE_STAGE_STALL_CNT_EN - when defined, stall_cnt counts cycles
//          with out_valid && !out_ready (not cleared by flush). When not
//          defined, stall_cnt is tied to zero.
// Ports  : clk        in   clock
//          reset      in   synchronous active-low reset
//          flush      in   discard all held entries
//          in_valid   in   upstream entry present
//          in_ready   out  stage can accept (registered)
//          pc_in      in   upstream PC
//          ctrl_in    in   upstream control {WrAddr, RegWr, MemtoReg}
//          data_in    in   upstream data {RdData, ALUOut, Ra}
//          out_valid  out  downstream entry present
//          out_ready  in   downstream accepts
//          pc_out     out  main-register PC
//          ctrl_out   out  main-register control
//          data_out   out  main-register data
//          stall_cnt  out  back-pressure cycle count
// Rev    : 1.0  initial release
// ============================================================================
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = 96,
  parameter int unsigned CTRL_W   = 8,
  parameter logic [31:0] PC_RESET = C_PC_RESET_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       pc_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       pc_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] data_out,
  output logic [31:0]       stall_cnt
);

  // --------------------------------------------------------------------------
  // State and payload registers
  // --------------------------------------------------------------------------
  stage_state_e      state_q,     state_d;
  logic              in_ready_q;

  logic [31:0]       pc_q,        pc_d;
  logic [CTRL_W-1:0] ctrl_q,      ctrl_d;
  logic [DATA_W-1:0] data_q,      data_d;

  logic [31:0]       skid_pc_q,   skid_pc_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic              w_accept;

  // Acceptance uses the registered ready so upstream sees exactly what we act on.
  assign w_accept = in_valid && in_ready_q;

  // --------------------------------------------------------------------------
  // Next-state and payload steering
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ctrl_d      = ctrl_q;
    data_d      = data_q;
    skid_pc_d   = skid_pc_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      // Flush wins over any transfer: an incoming entry is dropped, and an
      // entry leaving this cycle has already been taken by downstream.
      state_d     = ST_EMPTY;
      pc_d        = PC_RESET;
      ctrl_d      = '0;
      data_d      = '0;
      skid_pc_d   = '0;
      skid_ctrl_d = '0;
      skid_data_d = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (w_accept) begin
            state_d = ST_ONE;
            pc_d    = pc_in;
            ctrl_d  = ctrl_in;
            data_d  = data_in;
          end
        end

        ST_ONE: begin
          if (w_accept && out_ready) begin
            // Main drains and refills in the same cycle.
            pc_d   = pc_in;
            ctrl_d = ctrl_in;
            data_d = data_in;
          end else if (w_accept) begin
            // Downstream stalled: park the newcomer so main stays stable.
            state_d     = ST_FULL;
            skid_pc_d   = pc_in;
            skid_ctrl_d = ctrl_in;
            skid_data_d = data_in;
          end else if (out_ready) begin
            // Main keeps its last value; only validity drops.
            state_d = ST_EMPTY;
          end
        end

        ST_FULL: begin
          // in_ready is low here, so no upstream acceptance can occur.
          if (out_ready) begin
            state_d = ST_ONE;
            pc_d    = skid_pc_q;
            ctrl_d  = skid_ctrl_q;
            data_d  = skid_data_q;
          end
        end

        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registers (reset has priority over flush and all transfers)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      pc_q        <= PC_RESET;
      ctrl_q      <= '0;
      data_q      <= '0;
      skid_pc_q   <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      // Ready for next cycle is known from the next state alone.
      in_ready_q  <= (state_d != ST_FULL);
      pc_q        <= pc_d;
      ctrl_q      <= ctrl_d;
      data_q      <= data_d;
      skid_pc_q   <= skid_pc_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == ST_ONE) || (state_q == ST_FULL);
  assign pc_out    = pc_q;
  assign ctrl_out  = ctrl_q;
  assign data_out  = data_q;

  // --------------------------------------------------------------------------
  // Optional back-pressure counter
  // --------------------------------------------------------------------------
`ifdef PIPE_STAGE_STALL_CNT_EN
  stall_counter u_stall_counter (
    .clk   (clk),
    .reset (reset),
    .inc_i (out_valid && !out_ready),
    .cnt_o (stall_cnt)
  );
`else
  assign stall_cnt = '0;
`endif

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module : tb_pipe_stage_reg
// Brief  : Self-checking bench for pipe_stage_reg. A queue-based occupancy
//          model is compared against the DUT on every falling edge; directed
//          sequences add literal expectations and a delivered-PC log.
//          Build with PIPE_STAGE_STALL_CNT_EN to exercise the counter.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  ctrl;
    logic [95:0] data;
  } ent_t;

  localparam ent_t C_RST_ENT = '{pc: 32'h8000_0000, ctrl: 8'h00, data: 96'h0};

`ifdef PIPE_STAGE_STALL_CNT_EN
  localparam bit C_CNT_EN = 1'b1;
`else
  localparam bit C_CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] pc_in, pc_out, stall_cnt;
  logic [7:0]  ctrl_in, ctrl_out;
  logic [95:0] data_in, data_out;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // Model state
  ent_t        m_q[$];
  ent_t        m_show = C_RST_ENT;
  bit          m_rdy  = 1'b1;
  logic [31:0] m_cnt  = 32'h0;
  logic [31:0] dlv_log[$];

  pipe_stage_reg dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pc_in     (pc_in),
    .ctrl_in   (ctrl_in),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pc_out    (pc_out),
    .ctrl_out  (ctrl_out),
    .data_out  (data_out),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk_ent(input logic [31:0] pc);
    ent_t e;
    e.pc   = pc;
    e.ctrl = pack_ctrl(pc[1:0], pc[2], pc[7:3]) ^ 8'h3C;
    e.data = {pc, ~pc, pc ^ 32'h5A5A_5A5A};
    return e;
  endfunction

  task automatic drive_pc(input logic [31:0] pc);
    ent_t e;
    e       = mk_ent(pc);
    pc_in   = e.pc;
    ctrl_in = e.ctrl;
    data_in = e.data;
  endtask

  // Advance to just after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  // --------------------------------------------------------------------------
  // Model + compare: check outputs produced by the last rising edge, then
  // step the model with the inputs that the next rising edge will see.
  // --------------------------------------------------------------------------
  initial begin
    forever begin
      bit acc;
      @(negedge clk);
      if (chk_on) begin
        check("mdl_out_valid", out_valid, m_q.size() != 0);
        check("mdl_in_ready",  in_ready,  m_rdy);
        check("mdl_pc_out",    pc_out,    m_show.pc);
        check("mdl_ctrl_out",  ctrl_out,  m_show.ctrl);
        check("mdl_data_out",  data_out,  m_show.data);
        check("mdl_stall_cnt", stall_cnt, m_cnt);
        if (out_valid === 1'b1 && out_ready === 1'b1) dlv_log.push_back(pc_out);
      end
      if (!reset) begin
        m_q.delete();
        m_show = C_RST_ENT;
        m_rdy  = 1'b1;
        m_cnt  = 32'h0;
      end else begin
        if (C_CNT_EN && m_q.size() != 0 && !out_ready) m_cnt = m_cnt + 32'd1;
        if (flush) begin
          m_q.delete();
          m_show = C_RST_ENT;
          m_rdy  = 1'b1;
        end else begin
          acc = in_valid && m_rdy;
          if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
          if (acc) m_q.push_back(ent_t'({pc_in, ctrl_in, data_in}));
          m_rdy = (m_q.size() < 2);
          if (m_q.size() != 0) m_show = m_q[0];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // --------------------------------------------------------------------------
  initial begin
    logic [31:0] exp_log[8];
    logic [31:0] cnt_exp;
    exp_log = '{32'h100, 32'h104, 32'h108, 32'hA, 32'hB, 32'h30, 32'h40, 32'h60};

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive_pc(32'h0);
    cycle();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_pc_out",    pc_out,    32'h8000_0000);
    check("rst_ctrl_out",  ctrl_out,  8'h00);
    check("rst_data_out",  data_out,  96'h0);
    check("rst_stall_cnt", stall_cnt, 32'h0);
    chk_on = 1'b1;

    // Streaming at full rate.
    reset = 1'b1; in_valid = 1'b1; drive_pc(32'h100);
    cycle();
    check("str0_pc", pc_out, 32'h100); check("str0_rdy", in_ready, 1'b1);
    drive_pc(32'h104);
    cycle();
    check("str1_pc", pc_out, 32'h104); check("str1_rdy", in_ready, 1'b1);
    drive_pc(32'h108);
    cycle();
    check("str2_pc", pc_out, 32'h108); check("str2_data", data_out, mk_ent(32'h108).data);
    in_valid = 1'b0;
    cycle();
    check("str_drain_valid", out_valid, 1'b0);

    // Back-pressure into the skid register.
    out_ready = 1'b0; in_valid = 1'b1; drive_pc(32'hA);
    cycle();
    check("bp_one_pc", pc_out, 32'hA); check("bp_one_rdy", in_ready, 1'b1);
    drive_pc(32'hB);
    cycle();
    check("bp_full_rdy", in_ready, 1'b0); check("bp_full_pc", pc_out, 32'hA);
    drive_pc(32'hD);   // offered while full: must not be taken
    cycle();
    check("bp_hold_pc", pc_out, 32'hA); check("bp_hold_valid", out_valid, 1'b1);
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    check("bp_skid_pc", pc_out, 32'hB); check("bp_skid_rdy", in_ready, 1'b1);
    cycle();
    check("bp_empty_valid", out_valid, 1'b0);

    // Flush while full with a coincident offer.
    out_ready = 1'b0; in_valid = 1'b1; drive_pc(32'h20);
    cycle();
    drive_pc(32'h24);
    cycle();
    check("fl_full_rdy", in_ready, 1'b0);
    flush = 1'b1; drive_pc(32'hC);
    cycle();
    check("fl_valid", out_valid, 1'b0);
    check("fl_rdy",   in_ready,  1'b1);
    check("fl_pc",    pc_out,    32'h8000_0000);
    check("fl_data",  data_out,  96'h0);
    flush = 1'b0; in_valid = 1'b0;
    cycle();
    check("fl_after_valid", out_valid, 1'b0);

    // Flush coincident with a downstream transfer.
    out_ready = 1'b1; in_valid = 1'b1; drive_pc(32'h30);
    cycle();
    flush = 1'b1; in_valid = 1'b0;
    cycle();
    check("fld_valid", out_valid, 1'b0);
    flush = 1'b0;

    // Stall counter: reset to start from zero, then five stalled cycles.
    reset = 1'b0;
    cycle();
    reset = 1'b1; out_ready = 1'b0; in_valid = 1'b1; drive_pc(32'h40);
    cycle();
    in_valid = 1'b0;
    repeat (5) cycle();
    cnt_exp = C_CNT_EN ? 32'd5 : 32'd0;
    check("cnt_five", stall_cnt, cnt_exp);
`ifdef PIPE_STAGE_STALL_CNT_EN
    dut.u_stall_counter.cnt_q = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
`endif
    cycle();
    cnt_exp = C_CNT_EN ? 32'hFFFF_FFFF : 32'd0;
    check("cnt_max", stall_cnt, cnt_exp);
    cycle();
    check("cnt_wrap", stall_cnt, 32'h0);
    out_ready = 1'b1;
    cycle();

    // Reset mid-stream; a reset pulse between edges must do nothing.
    out_ready = 1'b0; in_valid = 1'b1; drive_pc(32'h50);
    cycle();
    drive_pc(32'h54);
    cycle();
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("glitch_valid", out_valid, 1'b1);
    check("glitch_pc",    pc_out,    32'h50);
    check("glitch_rdy",   in_ready,  1'b0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    check("mrst_valid", out_valid, 1'b0);
    check("mrst_rdy",   in_ready,  1'b1);
    check("mrst_pc",    pc_out,    32'h8000_0000);
    check("mrst_ctrl",  ctrl_out,  8'h00);
    check("mrst_cnt",   stall_cnt, 32'h0);
    reset = 1'b1;

    // Single transfer after reset: skid must not resurface old entries.
    out_ready = 1'b1; in_valid = 1'b1; drive_pc(32'h60);
    cycle();
    check("post_pc", pc_out, 32'h60);
    in_valid = 1'b0;
    cycle();
    check("post_valid", out_valid, 1'b0);
    repeat (2) cycle();

    check("log_len", dlv_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < dlv_log.size()) check($sformatf("log_%0d", i), dlv_log[i], exp_log[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_pipe_stage_reg
`default_nettype wire

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 96, meaning the data payload width (RdData, ALUOut and Ra packed).
REQ-002 SHALL have parameter CTRL_W, default 8, meaning the control payload width (MemtoReg, RegWr and WrAddr packed).
REQ-003 SHALL have parameter PC_RESET, default 32'h8000_0000, meaning the pc_out value after reset or flush.
REQ-004 SHALL have ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  discard all held entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept.
- pc_in  in  32  upstream PC.
- ctrl_in  in  CTRL_W  upstream control.
- data_in  in  DATA_W  upstream data.
- out_valid  out  1  downstream entry present.
- out_ready  in  1  downstream accepts.
- pc_out  out  32  held PC.
- ctrl_out  out  CTRL_W  held control.
- data_out  out  DATA_W  held data.
- stall_cnt  out  32  count of back-pressure cycles.

Function
REQ-005 SHALL transfer an upstream entry when in_valid && in_ready at posedge; transfer downstream when out_valid && out_ready.
REQ-006 SHALL present an accepted entry on the outputs one cycle after acceptance (latency 1) and sustain 1 entry/cycle throughput while out_ready=1.
REQ-007 SHALL hold a main register and a one-entry skid register; states are EMPTY, ONE and FULL.
REQ-008 SHALL transition EMPTY->ONE on accept, with the entry going to main.
REQ-009 SHALL, in state ONE:
- accept && out_ready -> ONE, main replaced;
- accept && !out_ready -> FULL, entry to skid;
- !accept && out_ready -> EMPTY;
- otherwise hold.
REQ-010 SHALL, in state FULL: out_ready -> ONE with skid moved to main; otherwise hold.
REQ-011 SHALL drive in_ready from a register, equal to (next state != FULL), with no combinational in_ready-from-out_ready path.
REQ-012 SHALL assert out_valid iff the state is ONE or FULL; pc_out/ctrl_out/data_out always reflect the main register.
REQ-013 SHALL keep outputs stable while out_valid && !out_ready.
REQ-014 SHALL, on flush=1, go to EMPTY, set in_ready=1 and pc_out=PC_RESET, and zero ctrl_out, data_out and skid contents.
REQ-015 SHALL, on flush coincident with accept, drop the incoming entry.
REQ-016 SHALL, on flush coincident with a downstream transfer, count that entry as delivered; out_valid=0 next cycle.

Reset
REQ-017 SHALL, when reset=0 at posedge, set:
- state EMPTY, out_valid=0, in_ready=1;
- pc_out=PC_RESET, ctrl_out=0, data_out=0;
- skid=0, stall_cnt=0.
REQ-018 SHALL give reset priority over flush and all transfers; reset mid-operation discards both entries.

Configuration
REQ-019 SHALL, with macro PIPE_STAGE_STALL_CNT_EN defined, increment stall_cnt by 1 each cycle with out_valid && !out_ready, wrapping 32'hFFFF_FFFF->0, and not clear it on flush.
REQ-020 SHALL, without PIPE_STAGE_STALL_CNT_EN, keep the stall_cnt port and tie it to 0, with no counter logic instantiated.

Structure
REQ-021 SHALL take state encoding (EMPTY/ONE/FULL), the default PC_RESET constant, and the ctrl field offsets (MemtoReg[1:0], RegWr, WrAddr[4:0]) from shared package pipe_pkg.
REQ-022 SHALL implement the state machine and skid registers directly; no sub-module except an optional stall_counter instantiated under PIPE_STAGE_STALL_CNT_EN.

Verification
REQ-023 SHALL cover streaming: reset release, then in_valid=1 and out_ready=1 with pc_in 0x100,0x104,0x108 -> pc_out 0x100,0x104,0x108 on consecutive cycles, in_ready=1 throughout.
REQ-024 SHALL cover back-pressure: out_ready=0, pushes 0xA then 0xB -> state FULL, in_ready=0, pc_out=0xA held; out_ready=1 -> 0xA, then 0xB delivered, no loss or duplication.
REQ-025 SHALL cover flush while FULL plus a coincident in_valid with 0xC -> next cycle out_valid=0, in_ready=1, pc_out=0x8000_0000, 0xC never emitted.
REQ-026 SHALL cover reset mid-stream: reset=0 for one posedge while out_valid=1 -> all outputs at reset values; an asserted reset with no clock edge changes nothing.
REQ-027 SHALL cover the counter: with PIPE_STAGE_STALL_CNT_EN, 5 cycles out_valid=1 && out_ready=0 -> stall_cnt=5; preload near 32'hFFFF_FFFF -> wraps to 0; without the macro stall_cnt stays 0.
